reg_cmd_ctrl: RTL and testbench
===============================

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL provide parameter AddWidth, default 4, register address width.
REQ-002 SHALL provide parameter BusWidth, default 8, data/byte width.
REQ-003 SHALL provide parameter CMD_WR, default 8'hAA, write command opcode.
REQ-004 SHALL provide parameter CMD_RD, default 8'hBB, read command opcode.
REQ-005 SHALL provide parameter RD_TIMEOUT, default 8, max cycles waiting for read data.
REQ-006 SHALL have ports: CLK in 1 clock; RST in 1 reset. One clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports: RX_P_Data in BusWidth received byte; RX_D_VLD in 1 byte-valid pulse (one cycle per byte).
REQ-008 SHALL have ports: Address out AddWidth; WrEn out 1; RdEn out 1; WrData out BusWidth -- register-file request side.
REQ-009 SHALL have ports: RdData in BusWidth; RdData_Valid in 1 -- register-file response (level, may remain high after a read).
REQ-010 SHALL have ports: TX_P_Data out BusWidth; TX_D_VLD out 1 one-cycle send pulse; TX_Busy in 1 transmitter busy.
REQ-011 SHALL have ports: Err_Cmd out 1 pulse (bad opcode); Err_Timeout out 1 pulse (read timeout); Err_Drop out 1 pulse (byte dropped).

Function
REQ-012 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, WR_REQ, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND; all outputs registered.
REQ-013 IDLE + RX_D_VLD: byte==CMD_WR -> WR_ADDR; byte==CMD_RD -> RD_ADDR; other -> Err_Cmd=1 one cycle, stay IDLE.
REQ-014 WR_ADDR + RX_D_VLD: Address<=RX_P_Data[AddWidth-1:0] -> WR_DATA; upper bits ignored.
REQ-015 WR_DATA + RX_D_VLD: WrData<=RX_P_Data -> WR_REQ; WrEn=1 exactly one cycle (WR_REQ), then IDLE.
REQ-016 RD_ADDR + RX_D_VLD: Address latched -> RD_REQ; RdEn=1 exactly one cycle (RD_REQ), then RD_WAIT with timeout counter cleared.
REQ-017 RD_WAIT: RdData_Valid=1 -> capture RdData into TX_P_Data, -> TX_SEND; first eligible sample is the cycle after RdEn deasserts (stale-high valid acceptable since RdData updated at same edge).
REQ-018 RD_WAIT: counter reaches RD_TIMEOUT-1 without valid -> Err_Timeout=1 one cycle, -> IDLE, no TX.
REQ-019 TX_SEND: TX_Busy=0 -> TX_D_VLD=1 one cycle, -> IDLE; TX_Busy=1 -> hold, TX_P_Data stable, no timeout.
REQ-020 WrEn and RdEn SHALL never be high in the same cycle.
REQ-021 Address and WrData SHALL hold value after request until next latch.
REQ-022 RX_D_VLD in WR_REQ, RD_REQ, RD_WAIT, TX_SEND: byte discarded, Err_Drop=1 one cycle, state unaffected.
REQ-023 Back-to-back: new command byte accepted in IDLE the cycle after WR_REQ/TX_SEND exits.

Reset
REQ-024 RST=0 SHALL asynchronously force IDLE, counter 0, Address/WrData/TX_P_Data=0, WrEn/RdEn/TX_D_VLD/all Err=0.
REQ-025 Reset mid-transaction SHALL abandon it with no WrEn/RdEn/TX_D_VLD emitted after release until a fresh command.

Structure
REQ-026 Opcodes, state encoding and default widths SHALL reside in shared package sys_ctrl_pkg.
REQ-027 Timeout counter SHALL be a sub-module rd_timeout_cnt (clear, enable, expire pulse); FSM otherwise flat.

Verification
REQ-028 RX AA,05,3C -> one-cycle WrEn with Address=5, WrData=8'h3C; no RdEn; back to IDLE.
REQ-029 RX BB,05; model returns 8'h3C one cycle after RdEn, TX_Busy=0 -> TX_D_VLD pulse, TX_P_Data=8'h3C.
REQ-030 RX 8'h55 in IDLE -> Err_Cmd pulse, no WrEn/RdEn; next AA,02,11 completes normally.
REQ-031 RX BB,03, RdData_Valid held 0 -> Err_Timeout exactly 8 cycles after RD_WAIT entry, no TX_D_VLD.
REQ-032 Read with TX_Busy=1 for 20 cycles -> TX_D_VLD only after Busy drops, data unchanged; RX byte sent meanwhile -> Err_Drop pulse.
REQ-033 RST low after AA,07 -> no WrEn after release; outputs zero; subsequent AA,07,99 writes Address=7 data 8'h99.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the register command controller: default widths,
// command opcodes and the FSM state encoding.
package sys_ctrl_pkg;

  localparam int ADD_WIDTH_DEF  = 4;
  localparam int BUS_WIDTH_DEF  = 8;
  localparam int RD_TIMEOUT_DEF = 8;

  localparam logic [7:0] CMD_WR_DEF = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF = 8'hBB;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_ADDR = 3'd1;
  localparam state_t ST_WR_DATA = 3'd2;
  localparam state_t ST_WR_REQ  = 3'd3;
  localparam state_t ST_RD_ADDR = 3'd4;
  localparam state_t ST_RD_REQ  = 3'd5;
  localparam state_t ST_RD_WAIT = 3'd6;
  localparam state_t ST_TX_SEND = 3'd7;

endpackage

// File: rtl/rd_timeout_cnt.sv
// Read-response watchdog: counts enabled cycles and flags the cycle in which
// the count sits at LIMIT-1 while still enabled.
module rd_timeout_cnt #(
  parameter int LIMIT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_enable && (r_cnt == CntW'(LIMIT - 1));

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command decoder: turns write (opcode, addr, data) and read
// (opcode, addr) sequences into register-file requests and returns read data to TX.
module reg_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int                  AddWidth   = ADD_WIDTH_DEF,
  parameter int                  BusWidth   = BUS_WIDTH_DEF,
  parameter logic [BusWidth-1:0] CMD_WR     = BusWidth'(CMD_WR_DEF),
  parameter logic [BusWidth-1:0] CMD_RD     = BusWidth'(CMD_RD_DEF),
  parameter int                  RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BusWidth-1:0] RX_P_Data,
  input  logic                RX_D_VLD,
  output logic [AddWidth-1:0] Address,
  output logic                WrEn,
  output logic                RdEn,
  output logic [BusWidth-1:0] WrData,
  input  logic [BusWidth-1:0] RdData,
  input  logic                RdData_Valid,
  output logic [BusWidth-1:0] TX_P_Data,
  output logic                TX_D_VLD,
  input  logic                TX_Busy,
  output logic                Err_Cmd,
  output logic                Err_Timeout,
  output logic                Err_Drop
);

  state_t              r_state;
  logic [AddWidth-1:0] r_addr;
  logic [BusWidth-1:0] r_wr_data;
  logic [BusWidth-1:0] r_tx_data;
  logic                r_wr_en;
  logic                r_rd_en;
  logic                r_tx_vld;
  logic                r_err_cmd;
  logic                r_err_timeout;
  logic                r_err_drop;

  logic w_cnt_clear;
  logic w_cnt_enable;
  logic w_expire;
  logic w_busy_state;

  // The counter is cleared while the read strobe is out, so RD_WAIT starts at zero.
  assign w_cnt_clear  = (r_state == ST_RD_REQ);
  assign w_cnt_enable = (r_state == ST_RD_WAIT);

  assign w_busy_state = (r_state == ST_WR_REQ)  || (r_state == ST_RD_REQ) ||
                        (r_state == ST_RD_WAIT) || (r_state == ST_TX_SEND);

  rd_timeout_cnt #(
    .LIMIT (RD_TIMEOUT)
  ) u_rd_timeout_cnt (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_wr_data     <= '0;
      r_tx_data     <= '0;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_tx_vld      <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_tx_vld      <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_drop    <= RX_D_VLD && w_busy_state;

      case (r_state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_Data == CMD_WR) begin
              r_state <= ST_WR_ADDR;
            end else if (RX_P_Data == CMD_RD) begin
              r_state <= ST_RD_ADDR;
            end else begin
              r_err_cmd <= 1'b1;
            end
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            r_addr  <= RX_P_Data[AddWidth-1:0];
            r_state <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            r_wr_data <= RX_P_Data;
            r_wr_en   <= 1'b1;
            r_state   <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          r_state <= ST_IDLE;
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            r_addr  <= RX_P_Data[AddWidth-1:0];
            r_rd_en <= 1'b1;
            r_state <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // A valid that stayed high from a previous read is fine: RdData was
          // refreshed on the same edge that dropped RdEn.
          if (RdData_Valid) begin
            r_tx_data <= RdData;
            r_state   <= ST_TX_SEND;
          end else if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_TX_SEND: begin
          if (!TX_Busy) begin
            r_tx_vld <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Address     = r_addr;
  assign WrData      = r_wr_data;
  assign TX_P_Data   = r_tx_data;
  assign WrEn        = r_wr_en;
  assign RdEn        = r_rd_en;
  assign TX_D_VLD    = r_tx_vld;
  assign Err_Cmd     = r_err_cmd;
  assign Err_Timeout = r_err_timeout;
  assign Err_Drop    = r_err_drop;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: a per-cycle vector table for the main
// command flows plus hand-written timeout, TX-busy and reset sequences.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_Data = '0;
  logic       RX_D_VLD = 1'b0;
  logic [3:0] Address;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] WrData;
  logic [7:0] RdData = '0;
  logic       RdData_Valid = 1'b0;
  logic [7:0] TX_P_Data;
  logic       TX_D_VLD;
  logic       TX_Busy = 1'b0;
  logic       Err_Cmd;
  logic       Err_Timeout;
  logic       Err_Drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic       resp_en = 1'b1;
  logic [7:0] rf [16];

  always #5 CLK = ~CLK;

  reg_cmd_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_Data    (RX_P_Data),
    .RX_D_VLD     (RX_D_VLD),
    .Address      (Address),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .TX_P_Data    (TX_P_Data),
    .TX_D_VLD     (TX_D_VLD),
    .TX_Busy      (TX_Busy),
    .Err_Cmd      (Err_Cmd),
    .Err_Timeout  (Err_Timeout),
    .Err_Drop     (Err_Drop)
  );

  // Register-file model: answers a read one cycle after RdEn, valid is a level.
  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    if (!resp_en) begin
      RdData_Valid <= 1'b0;
    end else if (RdEn) begin
      RdData       <= rf[Address];
      RdData_Valid <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      n_checks++;
      if (WrEn && RdEn) begin
        n_fail++;
        $display("FAIL wr_rd_excl: WrEn=%0b RdEn=%0b, required not both 1", WrEn, RdEn);
      end
    end
  end

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       wren;
    logic       rden;
    logic [3:0] addr;
    logic [7:0] wrdata;
    logic       txvld;
    logic [7:0] txdata;
    logic       ecmd;
    logic       eto;
    logic       edrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic [7:0] d,
                              input logic wren, input logic rden,
                              input logic [3:0] addr, input logic [7:0] wrdata,
                              input logic txvld, input logic [7:0] txdata,
                              input logic ecmd, input logic eto, input logic edrop);
    vec_t v;
    v.vld = vld; v.d = d; v.wren = wren; v.rden = rden; v.addr = addr;
    v.wrdata = wrdata; v.txvld = txvld; v.txdata = txdata;
    v.ecmd = ecmd; v.eto = eto; v.edrop = edrop;
    return v;
  endfunction

  function automatic logic [25:0] pack_out();
    return {WrEn, RdEn, Address, WrData, TX_D_VLD, TX_P_Data, Err_Cmd, Err_Timeout, Err_Drop};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_D_VLD  = 1'b1;
    RX_P_Data = b;
    step();
    RX_D_VLD  = 1'b0;
    RX_P_Data = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // columns: vld d | wren rden addr wrdata txvld txdata ecmd eto edrop
    vecs.push_back(mk(1, 8'hAA, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 4'h5, 8'h00, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'h3C, 1, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'hBB, 0, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'h05, 0, 1, 4'h5, 8'h3C, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h5, 8'h3C, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h5, 8'h3C, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h5, 8'h3C, 1, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h5, 8'h3C, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'h55, 0, 0, 4'h5, 8'h3C, 0, 8'h3C, 1, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 0, 0, 4'h5, 8'h3C, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 4'h2, 8'h3C, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'h11, 1, 0, 4'h2, 8'h11, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h2, 8'h11, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 0, 0, 4'h2, 8'h11, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'h09, 0, 0, 4'h9, 8'h11, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'h77, 1, 0, 4'h9, 8'h77, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 0, 0, 4'h9, 8'h77, 0, 8'h3C, 0, 0, 1));
    vecs.push_back(mk(1, 8'hBB, 0, 0, 4'h9, 8'h77, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(1, 8'h09, 0, 1, 4'h9, 8'h77, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h9, 8'h77, 0, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h9, 8'h77, 0, 8'h77, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h9, 8'h77, 1, 8'h77, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 4'h9, 8'h77, 0, 8'h77, 0, 0, 0));

    // Reset state
    #12;
    chk("reset_outputs", {6'd0, pack_out()}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("post_reset_idle", {6'd0, pack_out()}, 32'd0);

    // Table-driven command flows
    foreach (vecs[i]) begin
      vec_t v;
      logic [25:0] exp_o;
      v = vecs[i];
      RX_D_VLD  = v.vld;
      RX_P_Data = v.d;
      step();
      exp_o = {v.wren, v.rden, v.addr, v.wrdata, v.txvld, v.txdata, v.ecmd, v.eto, v.edrop};
      chk($sformatf("vec%0d", i), {6'd0, pack_out()}, {6'd0, exp_o});
      $display("vec %0d: rx_vld=%0b rx=%02h -> out=%07h", i, v.vld, v.d, pack_out());
    end
    RX_D_VLD = 1'b0;
    RX_P_Data = '0;

    // Read timeout: register file never answers
    resp_en = 1'b0;
    step();
    step();
    send(8'hBB);
    send(8'h03);
    chk("to_rden", {31'd0, RdEn}, 32'd1);
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("to_err_k%0d", k), {31'd0, Err_Timeout}, (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("to_txvld_k%0d", k), {31'd0, TX_D_VLD}, 32'd0);
    end
    $display("timeout read of addr 3 done");

    // Read held off by a busy transmitter, with a byte dropped while waiting
    resp_en = 1'b1;
    TX_Busy = 1'b1;
    send(8'hBB);
    send(8'h05);
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        send(8'hAA);
        chk("busy_drop", {31'd0, Err_Drop}, 32'd1);
      end else begin
        step();
      end
      chk($sformatf("busy_txvld_k%0d", k), {31'd0, TX_D_VLD}, 32'd0);
      chk($sformatf("busy_txdata_k%0d", k), {24'd0, TX_P_Data}, 32'h3C);
    end
    TX_Busy = 1'b0;
    step();
    chk("busy_release_txvld", {31'd0, TX_D_VLD}, 32'd1);
    chk("busy_release_txdata", {24'd0, TX_P_Data}, 32'h3C);
    step();
    chk("busy_after_txvld", {31'd0, TX_D_VLD}, 32'd0);
    $display("busy read of addr 5 sent 0x%02h", TX_P_Data);

    // Reset in the middle of a write
    send(8'hAA);
    send(8'h07);
    #2;
    RST = 1'b0;
    #1;
    chk("midreset_outputs", {6'd0, pack_out()}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("midreset_quiet_k%0d", k), {6'd0, pack_out()}, 32'd0);
    end
    send(8'hAA);
    send(8'h07);
    send(8'h99);
    chk("rewrite_wren", {31'd0, WrEn}, 32'd1);
    chk("rewrite_addr", {28'd0, Address}, 32'd7);
    chk("rewrite_data", {24'd0, WrData}, 32'h99);
    step();
    chk("rewrite_wren_drop", {31'd0, WrEn}, 32'd0);
    $display("write after reset: addr=%0d data=0x%02h", Address, WrData);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
